acc_wb_scoreboard: RTL

- Core-side stage directly upstream of the accelerator adapter; consumes the adapter's offload handshake and response channel.
- Tracks destination registers of accepted offloads that need writeback, and drives the per-source-operand `rs_valid` bits back into the offload request.
- Blocks write-after-write (WAW) and overflow issue, and retires responses into one register-file write port.

---
 rtl/acc_pkg.sv | 18 +
 rtl/acc_wb_scoreboard.sv | 133 +++++++++++++
 2 files changed

// File: rtl/acc_pkg.sv
// Shared constants and types for the accelerator offload path.
// Instruction field offsets and the writeback bundle.
package acc_pkg;

    localparam int RegAddrWidth = 5;
    localparam int AccDataWidth = 32;

    localparam int RdLsb  = 7;
    localparam int Rs1Lsb = 15;
    localparam int Rs2Lsb = 20;
    localparam int Rs3Lsb = 27;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic [AccDataWidth-1:0] data;
    } acc_wb_t;

endpackage

// File: rtl/acc_wb_scoreboard.sv
// Writeback scoreboard for accelerator offloads; retires responses to the RF.
// Define ACC_WB_SCOREBOARD_RSP_REG_EN for a one-entry p->wb output register.
module acc_wb_scoreboard
    import acc_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    q_valid_i,
    input  logic                    q_ready_i,
    input  logic                    accept_i,
    input  logic                    writeback_i,
    input  logic [31:0]             instr_i,
    output logic [2:0]              rs_valid_o,
    output logic                    issue_ok_o,
    input  logic                    p_valid_i,
    output logic                    p_ready_o,
    input  logic [4:0]              p_id_i,
    input  logic [DataWidth-1:0]    p_data_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [4:0]              wb_addr_o,
    output logic [DataWidth-1:0]    wb_data_o,
    output logic [CntWidth-1:0]     outstanding_o,
    output logic                    err_o
);

    logic [RegAddrWidth-1:0] rd, rs1, rs2, rs3;
    logic [31:0]             busy_q, busy_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    issue_fire, retire_fire;
    logic                    inc, dec;
    logic                    unused_instr;

    assign rd  = instr_i[RdLsb  +: RegAddrWidth];
    assign rs1 = instr_i[Rs1Lsb +: RegAddrWidth];
    assign rs2 = instr_i[Rs2Lsb +: RegAddrWidth];
    assign rs3 = instr_i[Rs3Lsb +: RegAddrWidth];

    assign unused_instr = ^{instr_i[6:0], instr_i[14:12], instr_i[26:25]};

    // Response path: registered spill stage or straight pass-through.
`ifdef ACC_WB_SCOREBOARD_RSP_REG_EN
    logic                    wb_valid_q, wb_valid_d;
    logic [4:0]              wb_addr_q, wb_addr_d;
    logic [DataWidth-1:0]    wb_data_q, wb_data_d;

    assign p_ready_o = ~wb_valid_q | wb_ready_i;

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (p_valid_i && p_ready_o) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = p_id_i;
            wb_data_d  = p_data_i;
        end else if (wb_ready_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_addr_o  = wb_addr_q;
    assign wb_data_o  = wb_data_q;
`else
    assign wb_valid_o = p_valid_i;
    assign wb_addr_o  = p_id_i;
    assign wb_data_o  = p_data_i;
    assign p_ready_o  = wb_ready_i;
`endif

    assign issue_fire  = q_valid_i & q_ready_i & accept_i
                       & writeback_i & (rd != '0);
    assign retire_fire = wb_valid_o & wb_ready_i;

    assign inc = issue_fire;
    assign dec = retire_fire & busy_q[wb_addr_o];

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (retire_fire) begin
            if (busy_q[wb_addr_o]) busy_d[wb_addr_o] = 1'b0;
            else                   err_d             = 1'b1;
        end
        if (issue_fire) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
        unique case ({inc, dec})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign rs_valid_o[0] = (rs1 == '0) | ~busy_q[rs1];
    assign rs_valid_o[1] = (rs2 == '0) | ~busy_q[rs2];
    assign rs_valid_o[2] = (rs3 == '0) | ~busy_q[rs3];

    assign issue_ok_o    = ~busy_q[rd] & (cnt_q < CntWidth'(MaxOutstanding));
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule
